fft8_twiddle_mult: RTL and testbench

// - Pipelined complex twiddle multiplier for the 8-point FFT datapath.
// - Sits directly downstream of the butterfly difference output (r2r/r2i) and feeds the next radix-2 stage.
// - Multiplies one complex sample per cycle by W8^k, k=0..3, with round-half-up and saturation.
// - Valid/ready streaming, 3-cycle latency, full throughput when unstalled.

---
 rtl/fft8_pkg.sv | 35 +++
 rtl/fft8_twiddle_mult_if.sv | 30 +++
 rtl/fft8_twiddle_rom.sv | 20 ++
 rtl/fft8_twiddle_mult.sv | 108 ++++++++++
 tb/tb_fft8_twiddle_mult.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft8_pkg.sv
// Shared constants for the 8-point FFT datapath: Q-formats, W8 twiddles, rounding and clamping.
package fft8_pkg;

    // Data is Q2.13, coefficients Q1.14; products are shifted back by CFRAC.
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int CFRAC = 14;
    localparam int PW    = DW + CW;
    localparam int SW    = PW + 1;

    localparam logic signed [CW-1:0] W8_ONE  = CW'(16384);
    localparam logic signed [CW-1:0] W8_R2   = CW'(11585);
    localparam logic signed [CW-1:0] W8_ZERO = '0;

    localparam logic signed [SW-1:0] ROUND   = SW'(2 ** (CFRAC - 1));
    localparam logic signed [SW-1:0] SAT_MAX = SW'(2 ** (DW - 1) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (DW - 1)));

    localparam logic signed [DW-1:0] DW_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] DW_MIN = {1'b1, {(DW-1){1'b0}}};

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [SW-1:0] x);
        if (x > SAT_MAX) begin
            return DW_MAX;
        end else if (x < SAT_MIN) begin
            return DW_MIN;
        end
        return x[DW-1:0];
    endfunction

    function automatic logic is_clamped(input logic signed [SW-1:0] x);
        return (x > SAT_MAX) || (x < SAT_MIN);
    endfunction

endpackage

// File: rtl/fft8_twiddle_mult_if.sv
// Streaming port bundle of the twiddle multiplier: sample in, product out, overflow status.
interface fft8_twiddle_mult_if import fft8_pkg::*; ();

    // A beat moves on a side when valid && ready at the rising edge; while valid is
    // high and ready is low the sender holds data, k and last stable.
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic [1:0]           tw_idx;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    logic                 out_last;
    logic                 ovf;
    logic                 ovf_clr;

    modport master (
        output in_valid, in_re, in_im, tw_idx, in_last, out_ready, ovf_clr,
        input  in_ready, out_valid, out_re, out_im, out_last, ovf
    );

    modport slave (
        input  in_valid, in_re, in_im, tw_idx, in_last, out_ready, ovf_clr,
        output in_ready, out_valid, out_re, out_im, out_last, ovf
    );

endinterface

// File: rtl/fft8_twiddle_rom.sv
// Combinational W8^k lookup, k = 0..3, coefficients in Q1.14.
module fft8_twiddle_rom import fft8_pkg::*; (
    input  logic [1:0]           k,
    output logic signed [CW-1:0] wr,
    output logic signed [CW-1:0] wi
);

    always_comb begin
        wr = W8_ZERO;
        wi = W8_ZERO;
        unique case (k)
            2'd0: begin wr = W8_ONE;  wi = W8_ZERO; end
            2'd1: begin wr = W8_R2;   wi = -W8_R2;  end
            2'd2: begin wr = W8_ZERO; wi = -W8_ONE; end
            2'd3: begin wr = -W8_R2;  wi = -W8_R2;  end
            default: begin wr = W8_ZERO; wi = W8_ZERO; end
        endcase
    end

endmodule

// File: rtl/fft8_twiddle_mult.sv
// Three-stage complex twiddle multiplier: register+lookup, four products, combine/round/saturate.
module fft8_twiddle_mult import fft8_pkg::*; (
    input  logic                clk,
    input  logic                rst,
    fft8_twiddle_mult_if.slave  bus
);

    logic en1, en2, en3;
    logic v1, v2, v3;

    logic signed [CW-1:0] rom_wr, rom_wi;

    logic signed [DW-1:0] s1_re, s1_im;
    logic signed [CW-1:0] s1_wr, s1_wi;
    logic                 s1_last;

    logic signed [PW-1:0] s2_rr, s2_ii, s2_ri, s2_ir;
    logic                 s2_last;

    logic signed [SW-1:0] acc_re, acc_im, sh_re, sh_im;
    logic signed [DW-1:0] res_re, res_im;
    logic                 clamp_hit;

    logic signed [DW-1:0] o_re, o_im;
    logic                 o_last, ovf_q;

    fft8_twiddle_rom u_rom (
        .k  (bus.tw_idx),
        .wr (rom_wr),
        .wi (rom_wi)
    );

    // Each stage advances when it is empty or its successor advances, so bubbles collapse.
    assign en3 = !v3 || bus.out_ready;
    assign en2 = !v2 || en3;
    assign en1 = !v1 || en2;

    always_comb begin
        acc_re    = SW'(s2_rr) - SW'(s2_ii) + ROUND;
        acc_im    = SW'(s2_ri) + SW'(s2_ir) + ROUND;
        sh_re     = acc_re >>> CFRAC;
        sh_im     = acc_im >>> CFRAC;
        res_re    = sat_dw(sh_re);
        res_im    = sat_dw(sh_im);
        clamp_hit = is_clamped(sh_re) || is_clamped(sh_im);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            s1_re   <= '0;
            s1_im   <= '0;
            s1_wr   <= '0;
            s1_wi   <= '0;
            s1_last <= 1'b0;
            s2_rr   <= '0;
            s2_ii   <= '0;
            s2_ri   <= '0;
            s2_ir   <= '0;
            s2_last <= 1'b0;
            o_re    <= '0;
            o_im    <= '0;
            o_last  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (en1) begin
                v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_re   <= bus.in_re;
                    s1_im   <= bus.in_im;
                    s1_wr   <= rom_wr;
                    s1_wi   <= rom_wi;
                    s1_last <= bus.in_last;
                end
            end
            if (en2) begin
                v2 <= v1;
                if (v1) begin
                    s2_rr   <= s1_re * s1_wr;
                    s2_ii   <= s1_im * s1_wi;
                    s2_ri   <= s1_re * s1_wi;
                    s2_ir   <= s1_im * s1_wr;
                    s2_last <= s1_last;
                end
            end
            if (en3) begin
                v3 <= v2;
                if (v2) begin
                    o_re   <= res_re;
                    o_im   <= res_im;
                    o_last <= s2_last;
                end
            end
            // A clamp landing in the output register outranks a same-cycle clear.
            ovf_q <= (ovf_q && !bus.ovf_clr) || (en3 && v2 && clamp_hit);
        end
    end

    assign bus.in_ready  = en1;
    assign bus.out_valid = v3;
    assign bus.out_re    = o_re;
    assign bus.out_im    = o_im;
    assign bus.out_last  = o_last;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fft8_twiddle_mult.sv
// Bench for fft8_twiddle_mult: vector table, streaming/backpressure scoreboard, ovf and reset corners.
module tb_fft8_twiddle_mult;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fft8_twiddle_mult_if bus ();

    fft8_twiddle_mult dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int out_count = 0;
    int accept_cyc = 0;
    int out_cyc_q[$];
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic [1:0]         k;
        logic signed [15:0] ere;
        logic signed [15:0] eim;
        logic               eovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Independent reference: exact integer product, round half up, clamp to 16 bits.
    function automatic logic [32:0] model(input logic signed [15:0] re, input logic signed [15:0] im,
                                          input logic [1:0] k, input logic last);
        longint wr, wi, ar, ai, pr, pi;
        logic signed [15:0] ore, oim;
        ar = re;
        ai = im;
        case (k)
            2'd0: begin wr = 16384;  wi = 0;      end
            2'd1: begin wr = 11585;  wi = -11585; end
            2'd2: begin wr = 0;      wi = -16384; end
            default: begin wr = -11585; wi = -11585; end
        endcase
        pr = (ar * wr - ai * wi + 8192) >>> 14;
        pi = (ar * wi + ai * wr + 8192) >>> 14;
        if (pr > 32767) pr = 32767;
        if (pr < -32768) pr = -32768;
        if (pi > 32767) pi = 32767;
        if (pi < -32768) pi = -32768;
        ore = 16'(pr);
        oim = 16'(pi);
        return {last, ore, oim};
    endfunction

    // Driver: present one sample, push its expectation on the accepting edge.
    task automatic send(input logic signed [15:0] re, input logic signed [15:0] im,
                        input logic [1:0] k, input logic last, input logic [32:0] e);
        int n;
        bus.in_valid = 1'b1;
        bus.in_re    = re;
        bus.in_im    = im;
        bus.tw_idx   = k;
        bus.in_last  = last;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles required 1", n);
        end
        accept_cyc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_m(input logic signed [15:0] re, input logic signed [15:0] im,
                          input logic [1:0] k, input logic last);
        send(re, im, k, last, model(re, im, k, last));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        bus.ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.ovf_clr = 1'b0;
    endtask

    // Scoreboard: every accepted output must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            out_count++;
            out_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h required none", {bus.out_last, bus.out_re, bus.out_im});
            end else begin
                mon_e = exp_q.pop_front();
                check("out_sample", 64'({bus.out_last, bus.out_re, bus.out_im}), 64'(mon_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] r, i;
        logic [1:0] k;
        int base, gaps, n;

        vecs[0] = '{16'sd8192,   16'sd0,     2'd1, 16'sd5793,   -16'sd5792,  1'b0};
        vecs[1] = '{-16'sd12345, 16'sd777,   2'd0, -16'sd12345, 16'sd777,    1'b0};
        vecs[2] = '{16'sd8192,   16'sd4096,  2'd2, 16'sd4096,   -16'sd8192,  1'b0};
        vecs[3] = '{16'sd0,      16'sd8192,  2'd1, 16'sd5793,   16'sd5793,   1'b0};
        vecs[4] = '{16'sd8192,   16'sd0,     2'd3, -16'sd5792,  -16'sd5792,  1'b0};
        vecs[5] = '{-16'sd8192,  16'sd0,     2'd1, -16'sd5792,  16'sd5793,   1'b0};
        vecs[6] = '{16'sd32767,  16'sh8000,  2'd0, 16'sd32767,  16'sh8000,   1'b0};
        vecs[7] = '{16'sh8000,   16'sd0,     2'd2, 16'sd0,      16'sd32767,  1'b1};
        vecs[8] = '{16'sd32767,  16'sd32767, 2'd3, 16'sd0,      16'sh8000,   1'b1};

        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.tw_idx    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        bus.ovf_clr   = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_re",    64'(bus.out_re),    64'd0);
        check("rst_out_im",    64'(bus.out_im),    64'd0);
        check("rst_out_last",  64'(bus.out_last),  64'd0);
        check("rst_ovf",       64'(bus.ovf),       64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Vector table, one sample at a time so ovf can be attributed
        for (int v = 0; v < 9; v++) begin
            pulse_clr();
            out_cyc_q.delete();
            send(vecs[v].re, vecs[v].im, vecs[v].k, 1'b0, {1'b0, vecs[v].ere, vecs[v].eim});
            drain();
            check("vec_ovf", 64'(bus.ovf), 64'(vecs[v].eovf));
            if (v == 0) begin
                check("latency", 64'(out_cyc_q.size() > 0 ? out_cyc_q[0] - accept_cyc : -1), 64'd3);
            end
        end

        // Clear after saturation with no new overflow
        pulse_clr();
        @(negedge clk);
        check("ovf_cleared", 64'(bus.ovf), 64'd0);
        @(posedge clk);
        #1;

        // Clear held high while a saturating sample lands: set wins, then clears
        bus.ovf_clr = 1'b1;
        send(16'sh8000, 16'sd0, 2'd2, 1'b0, {1'b0, 16'sd0, 16'sd32767});
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ovf_set_wins", 64'(bus.ovf), 64'd1);
        @(negedge clk);
        check("ovf_clr_next", 64'(bus.ovf), 64'd0);
        bus.ovf_clr = 1'b0;
        drain();

        // Back-to-back frame of 8, last on the 8th
        out_cyc_q.delete();
        base = out_count;
        for (int s = 0; s < 8; s++) begin
            r = 16'($urandom_range(0, 65535));
            i = 16'($urandom_range(0, 65535));
            k = 2'($urandom_range(0, 3));
            send_m(r, i, k, s == 7);
        end
        drain();
        check("b2b_count", 64'(out_count - base), 64'd8);
        gaps = 0;
        for (int s = 1; s < out_cyc_q.size(); s++) begin
            if (out_cyc_q[s] != out_cyc_q[s-1] + 1) gaps++;
        end
        check("b2b_gaps", 64'(gaps), 64'd0);

        // Backpressure: stall output for 5 cycles mid-stream
        base = out_count;
        fork
            begin
                for (int s = 0; s < 10; s++) begin
                    r = 16'($urandom_range(0, 65535));
                    i = 16'($urandom_range(0, 65535));
                    k = 2'($urandom_range(0, 3));
                    send_m(r, i, k, s == 9);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (5) @(negedge clk);
                check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                check("stall_held", 64'(exp_q.size()), 64'd3);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stall_count", 64'(out_count - base), 64'd10);

        // Reset with two samples in flight
        send_m(16'sd1000, 16'sd2000, 2'd1, 1'b0);
        send_m(16'sd3000, -16'sd500, 2'd3, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = out_count;
        repeat (8) @(negedge clk);
        check("midrst_no_output", 64'(out_count - base), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
